// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and the legality check.
// Imported by the ALU core and by the command issuer.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OPC_W-1:0] OP_MOD  = 4'd3;
  localparam logic [OPC_W-1:0] OP_PAR  = 4'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd6;
  localparam logic [OPC_W-1:0] OP_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESPOND
  } issuer_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  function automatic logic is_legal_op(input logic [OPC_W-1:0] opc);
    return (opc <= OP_OR);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-port bundle for alu_cmd_issuer.
// slave = issuer view; master = controller/ALU-side view.
interface alu_cmd_issuer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [RES_W-1:0]  alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [OPC_W-1:0]  rsp_opcode;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_out, rsp_ready,
    output cmd_ready, alu_opcode, alu_in1, alu_in2,
    output rsp_valid, rsp_result, rsp_opcode, rsp_err
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_out, rsp_ready,
    input  cmd_ready, alu_opcode, alu_in1, alu_in2,
    input  rsp_valid, rsp_result, rsp_opcode, rsp_err
  );

endinterface

// File: rtl/alu_cmd_issuer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
// rdata_o presents the head entry whenever empty_o is low.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives them onto the combinational ALU port, waits the
// settle time, samples the result and returns it on the response channel.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issuer_if.slave  bus
);
  import alu_pkg::*;

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  issuer_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OPC_W-1:0]  alu_opcode_q;
  logic [DATA_W-1:0] alu_in1_q, alu_in2_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [RES_W-1:0]  rsp_result_q;
  logic [OPC_W-1:0]  rsp_opcode_q;

  alu_cmd_t cmd_in, head;
  logic     fifo_full, fifo_empty, fifo_pop, head_ok;

  assign cmd_in = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};

  sync_fifo #(
    .WIDTH($bits(alu_cmd_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (bus.cmd_valid),
    .wdata_i(cmd_in),
    .pop_i  (fifo_pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // rsp_valid is always high in RESPOND, so rsp_ready alone marks the handshake.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RESPOND) && bus.rsp_ready));
  assign head_ok  = is_legal_op(head.opcode) && !((head.opcode == OP_MOD) && (head.b == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_opcode_q <= OP_IDLE;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_result_q <= bus.alu_out;
            rsp_opcode_q <= alu_opcode_q;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (bus.rsp_ready && fifo_empty) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: ;
      endcase
      // Dispatch is shared by IDLE and the RESPOND handshake edge; it overrides the case above.
      if (fifo_pop) begin
        if (head_ok) begin
          alu_opcode_q <= head.opcode;
          alu_in1_q    <= head.a;
          alu_in2_q    <= head.b;
          cnt_q        <= CNT_W'(SETTLE_CYC - 1);
          rsp_valid_q  <= 1'b0;
          state_q      <= ST_ISSUE;
        end else begin
          rsp_result_q <= '0;
          rsp_opcode_q <= head.opcode;
          rsp_err_q    <= 1'b1;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESPOND;
        end
      end
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
